// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_state_t : sequencer states
//   pipe_ctl_t : bundle of pipeline register enables and flushes
//   CTL_*      : the four control patterns the sequencer can drive
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctl_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam pipe_ctl_t CTL_RUN    = 6'b111100;
    localparam pipe_ctl_t CTL_FREEZE = 6'b000000;
    localparam pipe_ctl_t CTL_FLUSH  = 6'b111111;
    // Hold PC and IF/ID, push a bubble into ID/EX, let the load move on to MEM.
    localparam pipe_ctl_t CTL_BUBBLE = 6'b001101;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the hazard controller.
//   master : hazard sources (ID/EX/MEM stages), drives the inputs
//   slave  : the controller, drives enables, flushes, redirect and counters
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_br_valid;
    logic             ex_mispredict;
    logic [31:0]      ex_redirect_pc;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write_en;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pc_redirect_en;
    logic [31:0]      pc_redirect_target;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_br_valid, ex_mispredict, ex_redirect_pc, dmem_req, dmem_ready,
        input  pc_write_en, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
               pc_redirect_en, pc_redirect_target, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_br_valid, ex_mispredict, ex_redirect_pc, dmem_req, dmem_ready,
        output pc_write_en, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
               pc_redirect_en, pc_redirect_target, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count this cycle
//   cnt        : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   hz   : hazard inputs (ID operands, EX load/branch, MEM handshake) and
//          the PC / IF-ID / ID-EX / EX-MEM enables, flushes, redirect and
//          saturating stall/flush counters
// Priority: data-memory freeze > branch mispredict > load-use.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam logic [1:0] BUB_INIT = 2'(LU_BUBBLES - 1);

    hz_state_t   state_q, state_d;
    hz_state_t   saved_q, saved_d;
    hz_state_t   eff_state;
    logic [1:0]  bub_q, bub_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        freeze;
    logic        br_mis;
    logic        load_use;
    logic        redirect;
    logic        stall_inc;
    logic        flush_inc;
    pipe_ctl_t   ctl;
    logic [CNT_W-1:0] stall_cnt_w;
    logic [CNT_W-1:0] flush_cnt_w;

    assign freeze   = hz.dmem_req & ~hz.dmem_ready;
    assign br_mis   = hz.ex_br_valid & hz.ex_mispredict;
    assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                       (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

    // MEM_WAIT only remembers that we were frozen; on release the pipeline
    // behaves as the state that was interrupted.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        bub_d     = bub_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        ctl       = CTL_RUN;
        redirect  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (freeze) begin
            ctl       = CTL_FREEZE;
            stall_inc = 1'b1;
            saved_d   = eff_state;
            state_d   = MEM_WAIT;
            // A branch resolved while frozen is remembered and replayed on release.
            if (br_mis) begin
                pend_d    = 1'b1;
                pend_pc_d = hz.ex_redirect_pc;
            end
        end else if (br_mis || pend_q) begin
            ctl       = CTL_FLUSH;
            redirect  = 1'b1;
            flush_inc = 1'b1;
            pend_d    = 1'b0;
            bub_d     = 2'd0;
            state_d   = RUN;
        end else if (eff_state == LU_STALL) begin
            ctl       = CTL_BUBBLE;
            stall_inc = 1'b1;
            bub_d     = bub_q - 2'd1;
            state_d   = (bub_q == 2'd1) ? RUN : LU_STALL;
        end else if (load_use) begin
            ctl       = CTL_BUBBLE;
            stall_inc = 1'b1;
            state_d   = RUN;
            if (LU_BUBBLES > 1) begin
                state_d = LU_STALL;
                bub_d   = BUB_INIT;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            saved_q   <= RUN;
            bub_q     <= 2'd0;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            bub_q     <= bub_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (stall_inc),
        .cnt   (stall_cnt_w)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (flush_inc),
        .cnt   (flush_cnt_w)
    );

    // Everything is held off while reset is asserted.
    assign hz.pc_write_en        = rst & ctl.pc_we;
    assign hz.if_id_we           = rst & ctl.if_id_we;
    assign hz.id_ex_we           = rst & ctl.id_ex_we;
    assign hz.ex_mem_we          = rst & ctl.ex_mem_we;
    assign hz.if_id_flush        = rst & ctl.if_id_flush;
    assign hz.id_ex_flush        = rst & ctl.id_ex_flush;
    assign hz.pc_redirect_en     = rst & redirect;
    assign hz.pc_redirect_target = pend_q ? pend_pc_q : hz.ex_redirect_pc;
    assign hz.stall_cnt          = stall_cnt_w;
    assign hz.flush_cnt          = flush_cnt_w;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LU_BUBBLES=1/CNT_W=32 and
// LU_BUBBLES=3/CNT_W=4) share stimulus; a rule-level model checks both every
// cycle, alongside a vector table and hand-written corner sequences.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) if_a ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  if_b ();

    pipe_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hz(if_a));
    pipe_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hz(if_b));

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        use1, use2;
        logic [4:0]  exrd;
        logic        memrd, brv, mis;
        logic [31:0] rpc;
        logic        dreq, drdy;
    } stim_t;

    typedef struct {
        logic [5:0]  ctl;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] stall;
        logic [31:0] flush;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
    } vec_t;

    typedef struct {
        int          bub_left;
        bit          pend;
        logic [31:0] pend_pc;
        longint      stall;
        longint      flush;
    } model_t;

    localparam logic [5:0] K_RUN = 6'b111100;
    localparam logic [5:0] K_BUB = 6'b001101;
    localparam logic [5:0] K_FLU = 6'b111111;
    localparam logic [5:0] K_FRZ = 6'b000000;

    int total = 0;
    int bad   = 0;
    model_t ma, mb;

    function automatic stim_t mk(int rs1, int rs2, int use1, int use2, int exrd, int memrd,
                                 int brv, int mis, logic [31:0] rpc, int dreq, int drdy);
        stim_t s;
        s.rs1 = 5'(rs1);  s.rs2 = 5'(rs2);
        s.use1 = 1'(use1); s.use2 = 1'(use2);
        s.exrd = 5'(exrd); s.memrd = 1'(memrd);
        s.brv = 1'(brv);  s.mis = 1'(mis);
        s.rpc = rpc;
        s.dreq = 1'(dreq); s.drdy = 1'(drdy);
        return s;
    endfunction

    function automatic obs_t ex(logic [5:0] ctl, logic redir, logic [31:0] tgt, int st, int fl);
        obs_t o;
        o.ctl = ctl; o.redir = redir; o.tgt = tgt;
        o.stall = 32'(st); o.flush = 32'(fl);
        return o;
    endfunction

    function automatic stim_t s_idle();
        return mk(1, 2, 1, 1, 3, 0, 0, 0, 32'h0, 0, 0);
    endfunction
    function automatic stim_t s_lu();
        return mk(1, 5, 0, 1, 5, 1, 0, 0, 32'h0, 0, 0);
    endfunction
    function automatic stim_t s_mis(logic [31:0] pc);
        return mk(1, 2, 1, 1, 3, 0, 1, 1, pc, 0, 0);
    endfunction
    function automatic stim_t s_frz(int br, logic [31:0] pc);
        return mk(1, 2, 1, 1, 3, 0, br, br, pc, 1, 0);
    endfunction

    // Reference: freeze beats branch beats pending bubbles beats a new load-use.
    function automatic void mstep(inout model_t m, input stim_t s, input int lub,
                                  input int w, output obs_t e);
        longint mx;
        bit frozen, br, lu;
        mx = (longint'(1) << w) - 1;
        frozen = s.dreq && !s.drdy;
        br = s.brv && s.mis;
        lu = s.memrd && (s.exrd != 0) &&
             ((s.use1 && s.exrd == s.rs1) || (s.use2 && s.exrd == s.rs2));
        e.stall = 32'(m.stall);
        e.flush = 32'(m.flush);
        e.redir = 1'b0;
        e.tgt   = 32'h0;
        if (frozen) begin
            e.ctl = K_FRZ;
            if (m.stall < mx) m.stall++;
            if (br) begin
                m.pend = 1;
                m.pend_pc = s.rpc;
            end
        end else if (br || m.pend) begin
            e.ctl = K_FLU;
            e.redir = 1'b1;
            e.tgt = m.pend ? m.pend_pc : s.rpc;
            if (m.flush < mx) m.flush++;
            m.pend = 0;
            m.bub_left = 0;
        end else if (m.bub_left > 0) begin
            e.ctl = K_BUB;
            if (m.stall < mx) m.stall++;
            m.bub_left--;
        end else if (lu) begin
            e.ctl = K_BUB;
            if (m.stall < mx) m.stall++;
            m.bub_left = lub - 1;
        end else begin
            e.ctl = K_RUN;
        end
    endfunction

    function automatic model_t mreset();
        model_t m;
        m.bub_left = 0; m.pend = 0; m.pend_pc = 32'h0; m.stall = 0; m.flush = 0;
        return m;
    endfunction

    task automatic drive(input stim_t s);
        if_a.id_rs1 = s.rs1;   if_b.id_rs1 = s.rs1;
        if_a.id_rs2 = s.rs2;   if_b.id_rs2 = s.rs2;
        if_a.id_use_rs1 = s.use1; if_b.id_use_rs1 = s.use1;
        if_a.id_use_rs2 = s.use2; if_b.id_use_rs2 = s.use2;
        if_a.ex_rd = s.exrd;   if_b.ex_rd = s.exrd;
        if_a.ex_memread = s.memrd; if_b.ex_memread = s.memrd;
        if_a.ex_br_valid = s.brv;  if_b.ex_br_valid = s.brv;
        if_a.ex_mispredict = s.mis; if_b.ex_mispredict = s.mis;
        if_a.ex_redirect_pc = s.rpc; if_b.ex_redirect_pc = s.rpc;
        if_a.dmem_req = s.dreq;   if_b.dmem_req = s.dreq;
        if_a.dmem_ready = s.drdy; if_b.dmem_ready = s.drdy;
    endtask

    function automatic obs_t get_a();
        obs_t o;
        o.ctl = {if_a.pc_write_en, if_a.if_id_we, if_a.id_ex_we, if_a.ex_mem_we,
                 if_a.if_id_flush, if_a.id_ex_flush};
        o.redir = if_a.pc_redirect_en;
        o.tgt = if_a.pc_redirect_target;
        o.stall = if_a.stall_cnt;
        o.flush = if_a.flush_cnt;
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o.ctl = {if_b.pc_write_en, if_b.if_id_we, if_b.id_ex_we, if_b.ex_mem_we,
                 if_b.if_id_flush, if_b.id_ex_flush};
        o.redir = if_b.pc_redirect_en;
        o.tgt = if_b.pc_redirect_target;
        o.stall = 32'(if_b.stall_cnt);
        o.flush = 32'(if_b.flush_cnt);
        return o;
    endfunction

    task automatic chk(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got.ctl !== exp.ctl || got.redir !== exp.redir ||
            (exp.redir && got.tgt !== exp.tgt) ||
            got.stall !== exp.stall || got.flush !== exp.flush) begin
            bad++;
            $display("FAIL %s: got ctl=%b redir=%b tgt=%h stall=%0d flush=%0d, want ctl=%b redir=%b tgt=%h stall=%0d flush=%0d",
                     name, got.ctl, got.redir, got.tgt, got.stall, got.flush,
                     exp.ctl, exp.redir, exp.tgt, exp.stall, exp.flush);
        end
    endtask

    // One clock: inputs already settled after the previous edge, sample at negedge.
    task automatic cyc(input stim_t s, output obs_t ga, output obs_t gb);
        obs_t ea, eb;
        drive(s);
        @(negedge clk);
        ga = get_a();
        gb = get_b();
        mstep(ma, s, 1, 32, ea);
        mstep(mb, s, 3, 4, eb);
        chk("model_a", ga, ea);
        chk("model_b", gb, eb);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        obs_t z;
        z = ex(K_FRZ, 1'b0, 32'h0, 0, 0);
        rst = 1'b0;
        #2;
        chk("reset_a", get_a(), z);
        chk("reset_b", get_b(), z);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ma = mreset();
        mb = mreset();
    endtask

    vec_t tbl[$];
    obs_t ga, gb;
    stim_t rs;

    initial begin
        ma = mreset();
        mb = mreset();

        for (int i = 0; i < 10; i++) tbl.push_back('{s_idle(), ex(K_RUN, 0, 0, 0, 0)});
        tbl.push_back('{s_lu(),   ex(K_BUB, 0, 0, 0, 0)});
        tbl.push_back('{s_idle(), ex(K_RUN, 0, 0, 1, 0)});
        tbl.push_back('{mk(0, 2, 1, 0, 0, 1, 0, 0, 32'h0, 0, 0), ex(K_RUN, 0, 0, 1, 0)});
        tbl.push_back('{mk(7, 2, 0, 0, 7, 1, 0, 0, 32'h0, 0, 0), ex(K_RUN, 0, 0, 1, 0)});
        tbl.push_back('{s_mis(32'h100), ex(K_FLU, 1, 32'h100, 1, 0)});
        tbl.push_back('{mk(1, 2, 1, 1, 3, 0, 1, 0, 32'h111, 0, 0), ex(K_RUN, 0, 0, 1, 1)});
        tbl.push_back('{mk(1, 5, 0, 1, 5, 1, 1, 1, 32'h180, 0, 0), ex(K_FLU, 1, 32'h180, 1, 1)});
        tbl.push_back('{s_idle(), ex(K_RUN, 0, 0, 1, 2)});
        tbl.push_back('{s_frz(0, 32'h0),   ex(K_FRZ, 0, 0, 1, 2)});
        tbl.push_back('{s_frz(1, 32'h200), ex(K_FRZ, 0, 0, 2, 2)});
        tbl.push_back('{s_frz(0, 32'h0),   ex(K_FRZ, 0, 0, 3, 2)});
        tbl.push_back('{mk(1, 2, 1, 1, 3, 0, 0, 0, 32'h999, 1, 1), ex(K_FLU, 1, 32'h200, 4, 2)});
        tbl.push_back('{s_idle(), ex(K_RUN, 0, 0, 4, 3)});
        tbl.push_back('{s_idle(), ex(K_RUN, 0, 0, 4, 3)});

        // Reset asserted with a mispredict on the inputs: nothing may be driven.
        drive(s_mis(32'h55));
        #12;
        chk("reset_a", get_a(), ex(K_FRZ, 0, 0, 0, 0));
        chk("reset_b", get_b(), ex(K_FRZ, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].s, ga, gb);
            chk($sformatf("vec%0d", i), ga, tbl[i].e);
        end

        // Three-bubble instance: abort in bubble 2, then a full stall.
        reset_pulse();
        cyc(s_lu(), ga, gb);           chk("b_lu1",     gb, ex(K_BUB, 0, 0, 0, 0));
        cyc(s_mis(32'h300), ga, gb);   chk("b_abort",   gb, ex(K_FLU, 1, 32'h300, 1, 0));
        cyc(s_idle(), ga, gb);         chk("b_run",     gb, ex(K_RUN, 0, 0, 1, 1));
        cyc(s_lu(), ga, gb);           chk("b_bub1",    gb, ex(K_BUB, 0, 0, 1, 1));
        cyc(s_idle(), ga, gb);         chk("b_bub2",    gb, ex(K_BUB, 0, 0, 2, 1));
        cyc(s_idle(), ga, gb);         chk("b_bub3",    gb, ex(K_BUB, 0, 0, 3, 1));
        cyc(s_idle(), ga, gb);         chk("b_back",    gb, ex(K_RUN, 0, 0, 4, 1));

        // Reset while in LU_STALL with a pending redirect: the redirect is lost.
        cyc(s_lu(), ga, gb);           chk("b_lu_pre",  gb, ex(K_BUB, 0, 0, 4, 1));
        cyc(s_frz(1, 32'h400), ga, gb); chk("b_pend",   gb, ex(K_FRZ, 0, 0, 5, 1));
        drive(s_idle());
        reset_pulse();
        cyc(s_idle(), ga, gb);         chk("b_post_rst", gb, ex(K_RUN, 0, 0, 0, 0));
        cyc(s_idle(), ga, gb);         chk("b_post_rst2", gb, ex(K_RUN, 0, 0, 0, 0));

        // 4-bit stall counter must stick at 15.
        for (int i = 0; i < 20; i++) cyc(s_frz(0, 32'h0), ga, gb);
        chk("b_sat", gb, ex(K_FRZ, 0, 0, 15, 0));
        cyc(s_idle(), ga, gb);         chk("b_sat_hold", gb, ex(K_RUN, 0, 0, 15, 0));

        // Random traffic, small register range so hazards collide often.
        for (int i = 0; i < 500; i++) begin
            rs = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
                    $urandom, int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 1)));
            cyc(rs, ga, gb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
